// File: rtl/id_queue.sv
// id_queue: RISC-V decode stage followed by a DEPTH-entry output FIFO.
//
// Each instruction accepted on the fetch side is decoded combinationally in
// its arrival cycle. The decoded bundle is then written into the queue. All
// out_* fields come straight from queue storage, so there is no
// combinational path from in_* to out_*.
//
// Parameters:
//   XLEN  - datapath width, 32 or 64
//   DEPTH - queue entries, power of two in 2..16
//   HAS_M - 1 decodes the M extension, 0 reports M ops as illegal
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   flush               synchronous queue clear; overrides push and pop
//   in_valid/in_ready   fetch-side handshake (in_ready is registered)
//   in_instr, in_pc     raw instruction and its PC
//   out_valid/out_ready issue-side handshake (out_valid is registered)
//   out_*               decoded head-entry bundle
//   count               queue occupancy
module id_queue #(
  parameter int XLEN  = 64,
  parameter int DEPTH = 4,
  parameter int HAS_M = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_instr,
  input  logic [XLEN-1:0]          in_pc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [XLEN-1:0]          out_pc,
  output logic [31:0]              out_instr,
  output logic [4:0]               out_rs1,
  output logic [4:0]               out_rs2,
  output logic [4:0]               out_rd,
  output logic                     out_rd_we,
  output logic [XLEN-1:0]          out_imm,
  output logic [11:0]              out_opclass,
  output logic [17:0]              out_alu_op,
  output logic                     out_word,
  output logic [5:0]               out_branch_op,
  output logic [6:0]               out_load_op,
  output logic [3:0]               out_store_op,
  output logic [7:0]               out_csr_op,
  output logic [11:0]              out_csr_addr,
  output logic                     out_illegal,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);
  localparam bit RV64 = (XLEN == 64);
  localparam bit M_EN = (HAS_M != 0);

  localparam logic [6:0] OP_ALUR   = 7'b0110011;
  localparam logic [6:0] OP_ALUI   = 7'b0010011;
  localparam logic [6:0] OP_ALURW  = 7'b0111011;
  localparam logic [6:0] OP_ALUIW  = 7'b0011011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  // out_opclass bit positions
  localparam int OC_BRANCH = 0;
  localparam int OC_JAL    = 1;
  localparam int OC_JALR   = 2;
  localparam int OC_STORE  = 3;
  localparam int OC_LOAD   = 4;
  localparam int OC_ALUR   = 5;
  localparam int OC_ALURW  = 6;
  localparam int OC_ALUI   = 7;
  localparam int OC_ALUIW  = 8;
  localparam int OC_LUI    = 9;
  localparam int OC_AUIPC  = 10;
  localparam int OC_SYSTEM = 11;

  // out_alu_op bit positions
  localparam int ALU_ADD    = 0;
  localparam int ALU_SUB    = 1;
  localparam int ALU_SLL    = 2;
  localparam int ALU_SLT    = 3;
  localparam int ALU_SLTU   = 4;
  localparam int ALU_XOR    = 5;
  localparam int ALU_SRL    = 6;
  localparam int ALU_SRA    = 7;
  localparam int ALU_OR     = 8;
  localparam int ALU_AND    = 9;
  localparam int ALU_MUL    = 10;
  localparam int ALU_MULH   = 11;
  localparam int ALU_MULHU  = 12;
  localparam int ALU_MULHSU = 13;
  localparam int ALU_DIV    = 14;
  localparam int ALU_DIVU   = 15;
  localparam int ALU_REM    = 16;
  localparam int ALU_REMU   = 17;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic            rd_we;
    logic [XLEN-1:0] imm;
    logic [11:0]     opclass;
    logic [17:0]     alu_op;
    logic            word;
    logic [5:0]      branch_op;
    logic [6:0]      load_op;
    logic [3:0]      store_op;
    logic [7:0]      csr_op;
    logic [11:0]     csr_addr;
    logic            illegal;
  } bundle_t;

  // The 32-bit argument is already sign-extended to 32 bits. The signed
  // size cast carries the sign on to XLEN, and is a no-op for XLEN=32.
  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    logic signed [31:0] s;
    s = v;
    return XLEN'(s);
  endfunction

  // Register-register ALU ops with funct7=0 (also reused for alui non-shifts)
  function automatic logic [17:0] base_alu(input logic [2:0] f3);
    logic [17:0] r;
    r = '0;
    case (f3)
      3'b000:  r[ALU_ADD]  = 1'b1;
      3'b001:  r[ALU_SLL]  = 1'b1;
      3'b010:  r[ALU_SLT]  = 1'b1;
      3'b011:  r[ALU_SLTU] = 1'b1;
      3'b100:  r[ALU_XOR]  = 1'b1;
      3'b101:  r[ALU_SRL]  = 1'b1;
      3'b110:  r[ALU_OR]   = 1'b1;
      default: r[ALU_AND]  = 1'b1;
    endcase
    return r;
  endfunction

  function automatic logic [17:0] m_alu(input logic [2:0] f3);
    logic [17:0] r;
    r = '0;
    case (f3)
      3'b000:  r[ALU_MUL]    = 1'b1;
      3'b001:  r[ALU_MULH]   = 1'b1;
      3'b010:  r[ALU_MULHSU] = 1'b1;
      3'b011:  r[ALU_MULHU]  = 1'b1;
      3'b100:  r[ALU_DIV]    = 1'b1;
      3'b101:  r[ALU_DIVU]   = 1'b1;
      3'b110:  r[ALU_REM]    = 1'b1;
      default: r[ALU_REMU]   = 1'b1;
    endcase
    return r;
  endfunction

  // ---------------------------------------------------------------- decode
  logic [6:0]      opcode;
  logic [2:0]      f3;
  logic [6:0]      f7;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_j, imm_u, imm_z, shamt_i, shamt_w;
  logic            sh_std, sh_alt;

  assign opcode = in_instr[6:0];
  assign f3     = in_instr[14:12];
  assign f7     = in_instr[31:25];

  assign imm_i = sext32({{20{in_instr[31]}}, in_instr[31:20]});
  assign imm_s = sext32({{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]});
  assign imm_b = sext32({{19{in_instr[31]}}, in_instr[31], in_instr[7],
                         in_instr[30:25], in_instr[11:8], 1'b0});
  assign imm_j = sext32({{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                         in_instr[20], in_instr[30:21], 1'b0});
  assign imm_u = sext32({in_instr[31:12], 12'b0});
  assign imm_z = XLEN'(in_instr[19:15]);

  // RV64 alui shifts carry a 6-bit shamt and check only funct6; RV32 alui
  // shifts and every aluiw shift check the full funct7.
  assign sh_std  = RV64 ? (in_instr[31:26] == 6'b000000) : (f7 == 7'b0000000);
  assign sh_alt  = RV64 ? (in_instr[31:26] == 6'b010000) : (f7 == 7'b0100000);
  assign shamt_i = RV64 ? XLEN'(in_instr[25:20]) : XLEN'(in_instr[24:20]);
  assign shamt_w = XLEN'(in_instr[24:20]);

  logic [11:0]     d_opc;
  logic [17:0]     d_alu;
  logic [5:0]      d_br;
  logic [6:0]      d_ld;
  logic [3:0]      d_st;
  logic [7:0]      d_csr;
  logic [XLEN-1:0] d_imm;
  logic [11:0]     d_caddr;
  logic            d_word;
  logic            d_ill;
  logic            d_writes;
  bundle_t         dec;

  always_comb begin
    d_opc   = '0;
    d_alu   = '0;
    d_br    = '0;
    d_ld    = '0;
    d_st    = '0;
    d_csr   = '0;
    d_imm   = '0;
    d_word  = 1'b0;
    d_ill   = 1'b0;
    d_caddr = in_instr[31:20];
    case (opcode)
      OP_ALUR: begin
        d_opc[OC_ALUR] = 1'b1;
        case (f7)
          7'b0000000: d_alu = base_alu(f3);
          7'b0100000: begin
            if (f3 == 3'b000)      d_alu[ALU_SUB] = 1'b1;
            else if (f3 == 3'b101) d_alu[ALU_SRA] = 1'b1;
            else                   d_ill = 1'b1;
          end
          7'b0000001: begin
            if (M_EN) d_alu = m_alu(f3);
            else      d_ill = 1'b1;
          end
          default: d_ill = 1'b1;
        endcase
      end
      OP_ALUI: begin
        d_opc[OC_ALUI] = 1'b1;
        d_imm = imm_i;
        case (f3)
          3'b001: begin
            d_imm = shamt_i;
            if (sh_std) d_alu[ALU_SLL] = 1'b1;
            else        d_ill = 1'b1;
          end
          3'b101: begin
            d_imm = shamt_i;
            if (sh_std)      d_alu[ALU_SRL] = 1'b1;
            else if (sh_alt) d_alu[ALU_SRA] = 1'b1;
            else             d_ill = 1'b1;
          end
          default: d_alu = base_alu(f3);
        endcase
      end
      OP_ALURW: begin
        d_opc[OC_ALURW] = 1'b1;
        d_word = 1'b1;
        if (!RV64) d_ill = 1'b1;
        case (f7)
          7'b0000000: begin
            if (f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b101) d_alu = base_alu(f3);
            else d_ill = 1'b1;
          end
          7'b0100000: begin
            if (f3 == 3'b000)      d_alu[ALU_SUB] = 1'b1;
            else if (f3 == 3'b101) d_alu[ALU_SRA] = 1'b1;
            else                   d_ill = 1'b1;
          end
          7'b0000001: begin
            // mulw, divw, divuw, remw, remuw
            if (M_EN && (f3 == 3'b000 || f3[2])) d_alu = m_alu(f3);
            else d_ill = 1'b1;
          end
          default: d_ill = 1'b1;
        endcase
      end
      OP_ALUIW: begin
        d_opc[OC_ALUIW] = 1'b1;
        d_word = 1'b1;
        if (!RV64) d_ill = 1'b1;
        case (f3)
          3'b000: begin
            d_imm = imm_i;
            d_alu[ALU_ADD] = 1'b1;
          end
          3'b001: begin
            d_imm = shamt_w;
            if (f7 == 7'b0000000) d_alu[ALU_SLL] = 1'b1;
            else                  d_ill = 1'b1;
          end
          3'b101: begin
            d_imm = shamt_w;
            if (f7 == 7'b0000000)      d_alu[ALU_SRL] = 1'b1;
            else if (f7 == 7'b0100000) d_alu[ALU_SRA] = 1'b1;
            else                       d_ill = 1'b1;
          end
          default: d_ill = 1'b1;
        endcase
      end
      OP_LOAD: begin
        d_opc[OC_LOAD] = 1'b1;
        d_imm = imm_i;
        case (f3)
          3'b000: d_ld[0] = 1'b1;
          3'b001: d_ld[1] = 1'b1;
          3'b010: d_ld[2] = 1'b1;
          3'b011: begin d_ld[3] = 1'b1; if (!RV64) d_ill = 1'b1; end
          3'b100: d_ld[4] = 1'b1;
          3'b101: d_ld[5] = 1'b1;
          3'b110: begin d_ld[6] = 1'b1; if (!RV64) d_ill = 1'b1; end
          default: d_ill = 1'b1;
        endcase
      end
      OP_STORE: begin
        d_opc[OC_STORE] = 1'b1;
        d_imm = imm_s;
        case (f3)
          3'b000: d_st[0] = 1'b1;
          3'b001: d_st[1] = 1'b1;
          3'b010: d_st[2] = 1'b1;
          3'b011: begin d_st[3] = 1'b1; if (!RV64) d_ill = 1'b1; end
          default: d_ill = 1'b1;
        endcase
      end
      OP_BRANCH: begin
        d_opc[OC_BRANCH] = 1'b1;
        d_imm = imm_b;
        case (f3)
          3'b000: d_br[0] = 1'b1;
          3'b001: d_br[1] = 1'b1;
          3'b100: d_br[2] = 1'b1;
          3'b101: d_br[3] = 1'b1;
          3'b110: d_br[4] = 1'b1;
          3'b111: d_br[5] = 1'b1;
          default: d_ill = 1'b1;
        endcase
      end
      OP_JAL: begin
        d_opc[OC_JAL] = 1'b1;
        d_imm = imm_j;
      end
      OP_JALR: begin
        d_opc[OC_JALR] = 1'b1;
        d_imm = imm_i;
        if (f3 != 3'b000) d_ill = 1'b1;
      end
      OP_LUI: begin
        d_opc[OC_LUI] = 1'b1;
        d_imm = imm_u;
      end
      OP_AUIPC: begin
        d_opc[OC_AUIPC] = 1'b1;
        d_imm = imm_u;
      end
      OP_SYSTEM: begin
        d_opc[OC_SYSTEM] = 1'b1;
        case (f3)
          3'b000: begin
            // Only the exact ecall and mret words are accepted here; the
            // CSR address is forced to the register each one implicitly uses.
            if (in_instr == 32'h0000_0073) begin
              d_csr[6] = 1'b1;
              d_caddr  = 12'h305;
            end else if (in_instr == 32'h3020_0073) begin
              d_csr[7] = 1'b1;
              d_caddr  = 12'h341;
            end else begin
              d_ill = 1'b1;
            end
          end
          3'b001: d_csr[0] = 1'b1;
          3'b010: d_csr[1] = 1'b1;
          3'b011: d_csr[2] = 1'b1;
          3'b101: begin d_csr[3] = 1'b1; d_imm = imm_z; end
          3'b110: begin d_csr[4] = 1'b1; d_imm = imm_z; end
          3'b111: begin d_csr[5] = 1'b1; d_imm = imm_z; end
          default: d_ill = 1'b1;
        endcase
      end
      default: d_ill = 1'b1;
    endcase
  end

  assign d_writes = d_opc[OC_JAL] | d_opc[OC_JALR] | d_opc[OC_LOAD] |
                    d_opc[OC_ALUR] | d_opc[OC_ALURW] | d_opc[OC_ALUI] |
                    d_opc[OC_ALUIW] | d_opc[OC_LUI] | d_opc[OC_AUIPC] |
                    (|d_csr[5:0]);

  // An illegal entry keeps its PC, raw word and register fields but carries
  // no operation, so nothing downstream can act on it by mistake.
  always_comb begin
    dec           = '0;
    dec.pc        = in_pc;
    dec.instr     = in_instr;
    dec.rs1       = in_instr[19:15];
    dec.rs2       = in_instr[24:20];
    dec.rd        = in_instr[11:7];
    dec.csr_addr  = d_caddr;
    dec.illegal   = d_ill;
    if (!d_ill) begin
      dec.rd_we     = d_writes & (in_instr[11:7] != 5'd0);
      dec.imm       = d_imm;
      dec.opclass   = d_opc;
      dec.alu_op    = d_alu;
      dec.word      = d_word;
      dec.branch_op = d_br;
      dec.load_op   = d_ld;
      dec.store_op  = d_st;
      dec.csr_op    = d_csr;
    end
  end

  // ----------------------------------------------------------------- queue
  bundle_t          mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             valid_q, valid_d;
  logic             ready_q, ready_d;
  logic             push, pop;

  assign push = in_valid & ready_q & ~flush;
  assign pop  = valid_q & out_ready & ~flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
    // Handshake flags are registered from the next occupancy so neither
    // in_ready nor out_valid has a combinational path from the inputs.
    valid_d = (count_d != '0);
    ready_d = (count_d != FULL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= 1'b0;
      ready_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
      ready_q  <= ready_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (push) begin
      mem_q[wr_ptr_q] <= dec;
    end
  end

  // ---------------------------------------------------------------- output
  bundle_t head;
  assign head = mem_q[rd_ptr_q];

  assign in_ready      = ready_q;
  assign out_valid     = valid_q;
  assign count         = count_q;
  assign out_pc        = head.pc;
  assign out_instr     = head.instr;
  assign out_rs1       = head.rs1;
  assign out_rs2       = head.rs2;
  assign out_rd        = head.rd;
  assign out_rd_we     = head.rd_we;
  assign out_imm       = head.imm;
  assign out_opclass   = head.opclass;
  assign out_alu_op    = head.alu_op;
  assign out_word      = head.word;
  assign out_branch_op = head.branch_op;
  assign out_load_op   = head.load_op;
  assign out_store_op  = head.store_op;
  assign out_csr_op    = head.csr_op;
  assign out_csr_addr  = head.csr_addr;
  assign out_illegal   = head.illegal;

endmodule

// File: tb/tb_id_queue.sv
// Bench for id_queue: an XLEN=64/DEPTH=4 instance driven through a
// scoreboard, plus an XLEN=32/DEPTH=2 instance for RV32-only legality.
module tb_id_queue;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_instr, out_instr;
  logic [63:0] in_pc, out_pc, out_imm;
  logic [4:0]  out_rs1, out_rs2, out_rd;
  logic        out_rd_we, out_word, out_illegal;
  logic [11:0] out_opclass, out_csr_addr;
  logic [17:0] out_alu_op;
  logic [5:0]  out_branch_op;
  logic [6:0]  out_load_op;
  logic [3:0]  out_store_op;
  logic [7:0]  out_csr_op;
  logic [2:0]  count;

  id_queue #(.XLEN(64), .DEPTH(4), .HAS_M(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_instr(out_instr), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
    .out_rd_we(out_rd_we), .out_imm(out_imm), .out_opclass(out_opclass),
    .out_alu_op(out_alu_op), .out_word(out_word), .out_branch_op(out_branch_op),
    .out_load_op(out_load_op), .out_store_op(out_store_op), .out_csr_op(out_csr_op),
    .out_csr_addr(out_csr_addr), .out_illegal(out_illegal), .count(count)
  );

  logic        s_flush, s_valid, s_ready, s_ovalid, s_oready;
  logic [31:0] s_instr, s_pc, s_opc_pc, s_oinstr, s_imm;
  logic [4:0]  s_rs1, s_rs2, s_rd;
  logic        s_rd_we, s_word, s_ill;
  logic [11:0] s_opclass, s_caddr;
  logic [17:0] s_alu;
  logic [5:0]  s_br;
  logic [6:0]  s_ld;
  logic [3:0]  s_st;
  logic [7:0]  s_csr;
  logic [1:0]  s_count;

  id_queue #(.XLEN(32), .DEPTH(2), .HAS_M(1)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .flush(s_flush),
    .in_valid(s_valid), .in_ready(s_ready), .in_instr(s_instr), .in_pc(s_pc),
    .out_valid(s_ovalid), .out_ready(s_oready), .out_pc(s_opc_pc),
    .out_instr(s_oinstr), .out_rs1(s_rs1), .out_rs2(s_rs2), .out_rd(s_rd),
    .out_rd_we(s_rd_we), .out_imm(s_imm), .out_opclass(s_opclass),
    .out_alu_op(s_alu), .out_word(s_word), .out_branch_op(s_br),
    .out_load_op(s_ld), .out_store_op(s_st), .out_csr_op(s_csr),
    .out_csr_addr(s_caddr), .out_illegal(s_ill), .count(s_count)
  );

  typedef struct packed {
    logic [31:0] instr;
    logic [63:0] pc;
    logic [4:0]  rs1;
    logic [4:0]  rd;
    logic [11:0] opc;
    logic [17:0] alu;
    logic [5:0]  br;
    logic [6:0]  ld;
    logic [7:0]  csr;
    logic [11:0] caddr;
    logic [63:0] imm;
    logic        imm_chk;
    logic        rd_we;
    logic        word;
    logic        ill;
  } exp_t;

  int     n_tests = 0;
  int     n_fail  = 0;
  exp_t   sb[$];
  exp_t   tbl[14];
  exp_t   mon_e;
  logic [63:0] next_pc = 64'h1000;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] instr, input logic [4:0] rs1,
                              input logic [4:0] rd, input logic [11:0] opc,
                              input logic [17:0] alu, input logic [5:0] br,
                              input logic [6:0] ld, input logic [7:0] csr,
                              input logic [11:0] caddr, input logic [63:0] imm,
                              input logic imm_chk, input logic rd_we,
                              input logic word, input logic ill);
    exp_t e;
    e.instr = instr; e.pc = '0; e.rs1 = rs1; e.rd = rd; e.opc = opc;
    e.alu = alu; e.br = br; e.ld = ld; e.csr = csr; e.caddr = caddr;
    e.imm = imm; e.imm_chk = imm_chk; e.rd_we = rd_we; e.word = word; e.ill = ill;
    return e;
  endfunction

  // Scoreboard consumer: a pop happens at the next rising edge whenever the
  // head is valid, the consumer is ready and no flush is pending.
  always @(negedge clk) begin
    if (rst_n && !flush && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_pop", 64'(sb.size()), 64'd1);
      end else begin
        mon_e = sb.pop_front();
        chk("pc",       out_pc,        mon_e.pc);
        chk("instr",    out_instr,     mon_e.instr);
        chk("rs1",      out_rs1,       mon_e.rs1);
        chk("rd",       out_rd,        mon_e.rd);
        chk("opclass",  out_opclass,   mon_e.opc);
        chk("alu_op",   out_alu_op,    mon_e.alu);
        chk("br_op",    out_branch_op, mon_e.br);
        chk("ld_op",    out_load_op,   mon_e.ld);
        chk("csr_op",   out_csr_op,    mon_e.csr);
        chk("csr_addr", out_csr_addr,  mon_e.caddr);
        chk("rd_we",    out_rd_we,     mon_e.rd_we);
        chk("word",     out_word,      mon_e.word);
        chk("illegal",  out_illegal,   mon_e.ill);
        if (mon_e.imm_chk) chk("imm", out_imm, mon_e.imm);
      end
    end
  end

  // Presents one instruction for one cycle; it is expected at the head if
  // in_ready was high (and no flush) before the edge.
  task automatic push_one(input exp_t e, output logic acc);
    e.pc     = next_pc;
    next_pc  = next_pc + 64'd4;
    in_valid = 1'b1;
    in_instr = e.instr;
    in_pc    = e.pc;
    @(negedge clk);
    acc = in_ready & ~flush;
    if (acc) sb.push_back(e);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || out_valid) && n < 50) begin
      @(posedge clk);
      #2;
      n++;
    end
    chk("drain_timeout", 64'(n < 50), 64'd1);
  endtask

  task automatic push32(input logic [31:0] ins);
    s_valid = 1'b1;
    s_instr = ins;
    s_pc    = s_pc + 32'd4;
    @(posedge clk);
    #1;
    s_valid = 1'b0;
  endtask

  logic acc;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    //              instr         rs1 rd  opc     alu      br    ld     csr    caddr   imm                     chk we wd il
    tbl[0]  = mk(32'hFFF10093, 2,  1,  12'h080, 18'h1,   6'h0, 7'h0,  8'h0,  12'hFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1, 1, 0, 0);
    tbl[1]  = mk(32'h002081BB, 1,  3,  12'h040, 18'h1,   6'h0, 7'h0,  8'h0,  12'h002, 64'h0,                  0, 1, 1, 0);
    tbl[2]  = mk(32'h027302B3, 6,  5,  12'h020, 18'h400, 6'h0, 7'h0,  8'h0,  12'h027, 64'h0,                  0, 1, 0, 0);
    tbl[3]  = mk(32'h40208033, 1,  0,  12'h020, 18'h2,   6'h0, 7'h0,  8'h0,  12'h402, 64'h0,                  0, 0, 0, 0);
    tbl[4]  = mk(32'hFE208EE3, 1,  29, 12'h001, 18'h0,   6'h1, 7'h0,  8'h0,  12'hFE2, 64'hFFFF_FFFF_FFFF_FFFC, 1, 0, 0, 0);
    tbl[5]  = mk(32'h0080A283, 1,  5,  12'h010, 18'h0,   6'h0, 7'h04, 8'h0,  12'h008, 64'h8,                  1, 1, 0, 0);
    tbl[6]  = mk(32'h800003B7, 0,  7,  12'h200, 18'h0,   6'h0, 7'h0,  8'h0,  12'h800, 64'hFFFF_FFFF_8000_0000, 1, 1, 0, 0);
    tbl[7]  = mk(32'h00000073, 0,  0,  12'h800, 18'h0,   6'h0, 7'h0,  8'h40, 12'h305, 64'h0,                  0, 0, 0, 0);
    tbl[8]  = mk(32'h30200073, 0,  0,  12'h800, 18'h0,   6'h0, 7'h0,  8'h80, 12'h341, 64'h0,                  0, 0, 0, 0);
    tbl[9]  = mk(32'h4210D093, 1,  1,  12'h080, 18'h80,  6'h0, 7'h0,  8'h0,  12'h421, 64'd33,                 1, 1, 0, 0);
    tbl[10] = mk(32'h000000FF, 0,  1,  12'h000, 18'h0,   6'h0, 7'h0,  8'h0,  12'h000, 64'h0,                  0, 0, 0, 1);
    tbl[11] = mk(32'h10500073, 0,  0,  12'h000, 18'h0,   6'h0, 7'h0,  8'h0,  12'h105, 64'h0,                  0, 0, 0, 1);
    tbl[12] = mk(32'h3002D1F3, 5,  3,  12'h800, 18'h0,   6'h0, 7'h0,  8'h08, 12'h300, 64'd5,                  1, 1, 0, 0);
    tbl[13] = mk(32'h0000B103, 1,  2,  12'h010, 18'h0,   6'h0, 7'h08, 8'h0,  12'h000, 64'h0,                  1, 1, 0, 0);

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_instr = '0; in_pc = '0;
    s_flush = 1'b0; s_valid = 1'b0; s_oready = 1'b1; s_instr = '0; s_pc = 32'h2000;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count",   count,       64'd0);
    chk("rst_valid",   out_valid,   64'd0);
    chk("rst_imm",     out_imm,     64'd0);
    chk("rst_opclass", out_opclass, 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_ready", in_ready, 64'd1);

    // Single addi: visible one edge after acceptance
    push_one(tbl[0], acc);
    chk("lat_acc",   acc,       64'd1);
    chk("lat_valid", out_valid, 64'd1);
    chk("lat_count", count,     64'd1);
    @(posedge clk);
    #1;
    chk("hold_valid", out_valid, 64'd1);
    chk("hold_pc",    out_pc,    64'h1000);
    out_ready = 1'b1;
    wait_drain();

    // Back-to-back stream with a ready consumer: one per cycle
    for (int i = 1; i < 14; i++) begin
      push_one(tbl[i], acc);
      chk("tp_acc",   acc,   64'd1);
      chk("tp_count", count, 64'd1);
    end
    wait_drain();

    // Fill: five pushes into a 4-entry queue with no consumer
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      push_one(tbl[i + 2], acc);
      if (i < 4) chk("fill_acc", acc, 64'd1);
      else       chk("full_acc", acc, 64'd0);
      if (i == 3) begin
        chk("full_count", count,    64'd4);
        chk("full_ready", in_ready, 64'd0);
      end
    end
    chk("full_count2", count, 64'd4);
    out_ready = 1'b1;
    for (int k = 3; k >= 0; k--) begin
      @(posedge clk);
      #1;
      chk("drain_count", count, 64'(k));
    end
    wait_drain();

    // Flush with a concurrent push and pop at count=2
    out_ready = 1'b0;
    push_one(tbl[5], acc);
    push_one(tbl[6], acc);
    chk("pre_flush_count", count, 64'd2);
    flush = 1'b1; in_valid = 1'b1; in_instr = tbl[8].instr; out_ready = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_count", count,     64'd0);
    chk("flush_valid", out_valid, 64'd0);
    chk("flush_ready", in_ready,  64'd1);
    sb.delete();
    repeat (3) @(posedge clk);
    #1;
    chk("flush_noghost", out_valid, 64'd0);

    // Asynchronous reset mid-stream with count=3
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) push_one(tbl[i + 9], acc);
    chk("pre_rst_count", count, 64'd3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", out_valid, 64'd0);
    chk("arst_count", count,     64'd0);
    chk("arst_pc",    out_pc,    64'd0);
    chk("arst_instr", out_instr, 64'd0);
    sb.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("arst_ready", in_ready,  64'd1);
    chk("arst_idle",  out_valid, 64'd0);

    // RV32 instance: addw illegal, RV64 shamt illegal, ld illegal, addi legal
    push32(32'h002081BB);
    chk("rv32_addw_valid",   s_ovalid,  64'd1);
    chk("rv32_addw_ill",     s_ill,     64'd1);
    chk("rv32_addw_opclass", s_opclass, 64'd0);
    chk("rv32_addw_alu",     s_alu,     64'd0);
    chk("rv32_addw_word",    s_word,    64'd0);
    chk("rv32_addw_rd_we",   s_rd_we,   64'd0);
    chk("rv32_addw_rd",      s_rd,      64'd3);
    chk("rv32_addw_instr",   s_oinstr,  64'h002081BB);
    push32(32'h4210D093);
    chk("rv32_srai_ill",     s_ill,     64'd1);
    push32(32'h0000B103);
    chk("rv32_ld_ill",       s_ill,     64'd1);
    chk("rv32_ld_load_op",   s_ld,      64'd0);
    push32(32'hFFF10093);
    chk("rv32_addi_ill",     s_ill,     64'd0);
    chk("rv32_addi_imm",     s_imm,     64'hFFFF_FFFF);
    chk("rv32_addi_alu",     s_alu,     64'd1);
    chk("rv32_addi_opclass", s_opclass, 64'h080);
    chk("rv32_addi_rd_we",   s_rd_we,   64'd1);
    @(posedge clk);
    #1;
    chk("rv32_empty", s_ovalid, 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/id_queue.md
# id_queue

Parametrised decode stage with a registered output queue. It sits between fetch and the issue/execute stage. Each accepted 32-bit RISC-V instruction is decoded in the cycle it arrives, and the decoded bundle is written into a DEPTH-entry FIFO. The stage adds configurable XLEN (RV32/RV64), an optional M extension, illegal-instruction detection, valid/ready handshakes on both sides, and a synchronous flush.

## Interface
- XLEN, 64: datapath width. Only 32 and 64 are legal values.
- DEPTH, 4: queue entries. Must be a power of two, 2..16.
- HAS_M, 1: 1 decodes mul/div/rem; 0 treats them as illegal.
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous assert, active-low.
- flush  in  1  synchronous; discards all queued entries.
- in_valid  in  1  fetch presents an instruction.
- in_ready  out  1  queue can accept.
- in_instr  in  32  raw instruction.
- in_pc  in  XLEN  instruction PC.
- out_valid  out  1  head entry valid.
- out_ready  in  1  consumer takes the head entry.
- out_pc  out  XLEN  PC of the head entry.
- out_instr  out  32  raw instruction of the head entry.
- out_rs1, out_rs2, out_rd  out  5 each  register fields.
- out_rd_we  out  1  writes rd.
- out_imm  out  XLEN  selected immediate, sign-extended to XLEN.
- out_opclass  out  12  one-hot. Bit order {system, auipc, lui, aluiw, alui, alurw, alur, load, store, jalr, jal, branch}.
- out_alu_op  out  18  one-hot. Bit order {remu, rem, divu, div, mulhsu, mulhu, mulh, mul, and, or, sra, srl, xor, sltu, slt, sll, sub, add}.
- out_word  out  1  instruction is a *W op (32-bit result, sign-extended).
- out_branch_op  out  6  {geu, ltu, ge, lt, ne, eq}.
- out_load_op  out  7  {lwu, lhu, lbu, ld, lw, lh, lb}.
- out_store_op  out  4  {sd, sw, sh, sb}.
- out_csr_op  out  8  {mret, ecall, csrrci, csrrsi, csrrwi, csrrc, csrrs, csrrw}.
- out_csr_addr  out  12  instr[31:20]. Forced to 0x305 for ecall and 0x341 for mret.
- out_illegal  out  1  illegal encoding.
- count  out  $clog2(DEPTH)+1  occupancy.

## Operation
- Opcode encodings:
  - alur 0110011, alui 0010011, alurw 0111011, aluiw 0011011
  - load 0000011, store 0100011, branch 1100011
  - jal 1101111, jalr 1100111, lui 0110111, auipc 0010111, system 1110011
- Immediates are sign-extended from instr[31] to the full XLEN. This applies to I, S, B and J formats.
  - U-type: instr[31:12]<<12, sign-extended to XLEN.
  - CSR-immediate forms: zero-extended instr[19:15].
- Shift immediates:
  - XLEN=64 alui shifts check instr[31:26] (funct6) and use a 6-bit shamt.
  - XLEN=32 shifts, and all aluiw shifts, check funct7. instr[25]=1 is illegal.
- sllw/srlw/sraw/addw/subw decode only from alurw. They assert out_word plus the base ALU bit.
- Illegal conditions:
  - unknown opcode;
  - bad funct3 or funct7 combination;
  - any alurw/aluiw op, ld, sd or lwu when XLEN=32;
  - an M op when HAS_M=0;
  - a system instruction with funct3=000 other than ecall (0x00000073) or mret (0x30200073).
- For an illegal entry: every one-hot vector is zero, out_rd_we=0, out_illegal=1. PC, instr and register fields are still carried.
- out_rd_we=1 for jal, jalr, load, alu*, lui, auipc and the six CSR read ops, but only when rd≠0.
- Queue behaviour:
  - Push when in_valid&in_ready; pop when out_valid&out_ready.
  - in_ready = (count<DEPTH), computed from registered state only.
  - Push and pop in the same cycle: count unchanged. This is allowed at any count below DEPTH; at count=DEPTH only a pop occurs.
  - Pointers wrap modulo DEPTH.
- Flush: in the cycle after flush=1, count=0 and both pointers are 0. Flush overrides a same-cycle push and pop; neither takes effect.
- Reset (rst_n=0, immediate): count=0, pointers 0, out_valid=0, all storage zeroed, so every output bundle field reads 0. in_ready=1 as soon as reset deasserts.

## Timing
- Latency: an instruction accepted at edge N appears at the head at edge N+1 if the queue was empty. No combinational path exists from in_* to out_*.
- out_valid = (count≠0), driven from registers.
- out_* fields are held stable while out_valid=1 and out_ready=0.
- No combinational path from out_ready to in_ready.
- Throughput: 1 instruction per cycle when out_ready is held at 1.

## Test plan
- XLEN=64: push 0xFFF10093 (addi x1,x2,-1). Required: out_imm=0xFFFF_FFFF_FFFF_FFFF, alu add, opclass alui, rs1=2, rd=1, rd_we=1, illegal=0, one cycle after acceptance.
- XLEN=32: push 0x002081BB (addw). Required: out_illegal=1, all one-hot vectors 0, rd_we=0. With XLEN=64 the same word gives alurw, add, out_word=1.
- DEPTH=4, out_ready=0: push 5 instructions back to back. Required: in_ready falls after the 4th, count=4, the 5th is not accepted. Then set out_ready=1: entries drain in order, count decrements once per cycle.
- With count=2, assert flush together with in_valid and out_ready. Next cycle: count=0, out_valid=0, and the pushed word never appears.
- Push 0x00000073 then 0x30200073. Required: csr_op bit6 with csr_addr 0x305, then csr_op bit7 with csr_addr 0x341. rd_we=0 for both.
- Drop rst_n mid-stream with count=3. Required: out_valid=0 and count=0 immediately, without a clock edge; in_ready=1 after release.
